// File: rtl/fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage drives the request side; the memory returns ack and data.
interface fetch_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;

    modport master (output imem_req_out, output imem_addr_out,
                    input  imem_ack_in,  input  imem_data_in);
    modport slave  (input  imem_req_out, input  imem_addr_out,
                    output imem_ack_in,  output imem_data_in);
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests,
// buffers returned words in a small FIFO and hands one per cycle to decode.
module fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BUF_DEPTH    = 2
) (
    input  logic        req,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    fetch_if.master     imem,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);
    localparam int          PTR_W = $clog2(BUF_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        drop_addr_q, drop_addr_d;
    logic [31:0]        last_pc_q;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fifo_instr_q [BUF_DEPTH];
    logic [31:0]        fifo_pc_q    [BUF_DEPTH];
    logic               full, push, pop;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_in[1:0];

    assign full      = (count_q == CNT_W'(BUF_DEPTH));
    assign valid_out = (count_q != '0);
    assign instr_out = valid_out ? fifo_instr_q[rd_ptr_q] : NOP;
    assign pc_out    = valid_out ? fifo_pc_q[rd_ptr_q]    : last_pc_q;

    // Request gating on !full is what keeps a push from ever landing on a full FIFO.
    always_comb begin
        imem.imem_req_out  = 1'b0;
        imem.imem_addr_out = pc_q;
        case (state_q)
            S_FETCH: imem.imem_req_out = !full;
            S_DROP: begin
                imem.imem_req_out  = 1'b1;
                imem.imem_addr_out = drop_addr_q;
            end
            default: ;
        endcase
    end

    assign push = (state_q == S_FETCH) && imem.imem_req_out && imem.imem_ack_in && !redirect_in;
    assign pop  = valid_out && !stall_in && !redirect_in;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (redirect_in) begin
            pc_d     = {redirect_pc_in[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            // An unanswered request must still be completed; remember its address.
            if (imem.imem_req_out && !imem.imem_ack_in) begin
                state_d     = S_DROP;
                drop_addr_d = imem.imem_addr_out;
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: if (push) pc_d = pc_q + 32'd4;
                S_DROP:  if (imem.imem_ack_in) state_d = S_FETCH;
                default: state_d = S_IDLE;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge req or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_VECTOR;
            drop_addr_q <= RESET_VECTOR;
            last_pc_q   <= RESET_VECTOR;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            last_pc_q   <= pc_out;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge req) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem.imem_data_in;
            fifo_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

    assert property (@(posedge req) disable iff (reset) !(push && full && !pop));

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage with a small variable-latency imem model.
module tb_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    int nvec = 0;
    int nmis = 0;
    int lat  = 1;
    int wcnt = 0;

    fetch_if mif ();

    fetch #(.RESET_VECTOR(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .req            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .imem           (mif),
        .valid_out      (valid_out),
        .instr_out      (instr_out),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    // Memory answers after lat cycles of a held request (lat=1 is zero-wait).
    always_comb begin
        mif.imem_ack_in  = mif.imem_req_out && (wcnt >= lat - 1);
        mif.imem_data_in = mif.imem_ack_in ? (mif.imem_addr_out ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (!mif.imem_req_out || mif.imem_ack_in) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0; lat = 1;
        step();
        nvec++; if (valid_out !== 1'b0) begin nmis++; $display("FAIL reset_valid: got %b exp 0", valid_out); end
        nvec++; if (instr_out !== 32'h13) begin nmis++; $display("FAIL reset_instr: got %h exp 00000013", instr_out); end
        nvec++; if (pc_out !== 32'h0) begin nmis++; $display("FAIL reset_pc: got %h exp 00000000", pc_out); end
        nvec++; if (mif.imem_req_out !== 1'b0) begin nmis++; $display("FAIL reset_req: got %b exp 0", mif.imem_req_out); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        step();
        nvec++; if (mif.imem_req_out !== 1'b1) begin nmis++; $display("FAIL stream_req0: got %b exp 1", mif.imem_req_out); end
        nvec++; if (mif.imem_addr_out !== 32'h0) begin nmis++; $display("FAIL stream_addr0: got %h exp 0", mif.imem_addr_out); end
        nvec++; if (valid_out !== 1'b0) begin nmis++; $display("FAIL stream_valid_early: got %b exp 0", valid_out); end
        for (int k = 0; k < 6; k++) begin
            step();
            nvec++; if (valid_out !== 1'b1) begin nmis++; $display("FAIL stream_valid[%0d]: got %b exp 1", k, valid_out); end
            nvec++; if (pc_out !== 32'(4*k)) begin nmis++; $display("FAIL stream_pc[%0d]: got %h exp %h", k, pc_out, 32'(4*k)); end
            nvec++; if (instr_out !== (32'(4*k) ^ 32'hA5A5_0000)) begin nmis++; $display("FAIL stream_instr[%0d]: got %h exp %h", k, instr_out, 32'(4*k) ^ 32'hA5A5_0000); end
            nvec++; if (mif.imem_addr_out !== 32'(4*k+4)) begin nmis++; $display("FAIL stream_addr[%0d]: got %h exp %h", k, mif.imem_addr_out, 32'(4*k+4)); end
        end
    endtask

    task automatic test_stall();
        stall_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            nvec++; if (pc_out !== 32'h14) begin nmis++; $display("FAIL stall_pc[%0d]: got %h exp 00000014", i, pc_out); end
            nvec++; if (mif.imem_req_out !== 1'b0) begin nmis++; $display("FAIL stall_req[%0d]: got %b exp 0", i, mif.imem_req_out); end
            nvec++; if (valid_out !== 1'b1) begin nmis++; $display("FAIL stall_valid[%0d]: got %b exp 1", i, valid_out); end
        end
        stall_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            nvec++; if (pc_out !== 32'(24 + 4*k)) begin nmis++; $display("FAIL unstall_pc[%0d]: got %h exp %h", k, pc_out, 32'(24 + 4*k)); end
            nvec++; if (instr_out !== (32'(24 + 4*k) ^ 32'hA5A5_0000)) begin nmis++; $display("FAIL unstall_instr[%0d]: got %h exp %h", k, instr_out, 32'(24 + 4*k) ^ 32'hA5A5_0000); end
            nvec++; if (valid_out !== 1'b1) begin nmis++; $display("FAIL unstall_valid[%0d]: got %b exp 1", k, valid_out); end
        end
    endtask

    task automatic test_latency();
        lat = 3;
        apply_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            nvec++; if (mif.imem_req_out !== 1'b1) begin nmis++; $display("FAIL lat_req[%0d]: got %b exp 1", i, mif.imem_req_out); end
            nvec++; if (mif.imem_addr_out !== 32'h0) begin nmis++; $display("FAIL lat_addr[%0d]: got %h exp 0", i, mif.imem_addr_out); end
            nvec++; if (valid_out !== 1'b0) begin nmis++; $display("FAIL lat_valid[%0d]: got %b exp 0", i, valid_out); end
            step();
        end
        nvec++; if (valid_out !== 1'b1 || pc_out !== 32'h0) begin nmis++; $display("FAIL lat_first: got v=%b pc=%h exp v=1 pc=0", valid_out, pc_out); end
        nvec++; if (instr_out !== 32'hA5A5_0000) begin nmis++; $display("FAIL lat_first_instr: got %h exp a5a50000", instr_out); end
        nvec++; if (mif.imem_addr_out !== 32'h4) begin nmis++; $display("FAIL lat_addr4: got %h exp 4", mif.imem_addr_out); end
        for (int i = 0; i < 2; i++) begin
            step();
            nvec++; if (valid_out !== 1'b0 || instr_out !== 32'h13) begin nmis++; $display("FAIL lat_gap[%0d]: got v=%b i=%h exp v=0 i=00000013", i, valid_out, instr_out); end
            nvec++; if (mif.imem_addr_out !== 32'h4 || mif.imem_req_out !== 1'b1) begin nmis++; $display("FAIL lat_hold[%0d]: got req=%b addr=%h exp req=1 addr=4", i, mif.imem_req_out, mif.imem_addr_out); end
        end
        step();
        nvec++; if (valid_out !== 1'b1 || pc_out !== 32'h4) begin nmis++; $display("FAIL lat_second: got v=%b pc=%h exp v=1 pc=4", valid_out, pc_out); end
        nvec++; if (instr_out !== 32'hA5A5_0004) begin nmis++; $display("FAIL lat_second_instr: got %h exp a5a50004", instr_out); end
    endtask

    task automatic test_reset_midwait();
        reset = 1'b1;
        #1;
        nvec++; if (mif.imem_req_out !== 1'b0) begin nmis++; $display("FAIL midrst_req: got %b exp 0", mif.imem_req_out); end
        nvec++; if (valid_out !== 1'b0) begin nmis++; $display("FAIL midrst_valid: got %b exp 0", valid_out); end
        nvec++; if (pc_out !== 32'h0 || instr_out !== 32'h13) begin nmis++; $display("FAIL midrst_out: got pc=%h i=%h exp pc=0 i=00000013", pc_out, instr_out); end
        step();
        reset = 1'b0;
        step();
        nvec++; if (mif.imem_req_out !== 1'b1 || mif.imem_addr_out !== 32'h0) begin nmis++; $display("FAIL midrst_restart: got req=%b addr=%h exp req=1 addr=0", mif.imem_req_out, mif.imem_addr_out); end
        step(); step(); step();
        nvec++; if (valid_out !== 1'b1 || pc_out !== 32'h0) begin nmis++; $display("FAIL midrst_first: got v=%b pc=%h exp v=1 pc=0", valid_out, pc_out); end
    endtask

    task automatic test_redirect_inflight();
        lat = 1;
        apply_reset();
        repeat (5) step();
        nvec++; if (pc_out !== 32'hC || mif.imem_addr_out !== 32'h10) begin nmis++; $display("FAIL redir_setup: got pc=%h addr=%h exp pc=c addr=10", pc_out, mif.imem_addr_out); end
        lat = 3;
        redirect_in = 1'b1; redirect_pc_in = 32'h0000_0103;
        step();
        redirect_in = 1'b0; redirect_pc_in = '0;
        nvec++; if (valid_out !== 1'b0) begin nmis++; $display("FAIL redir_flush: got %b exp 0", valid_out); end
        nvec++; if (mif.imem_req_out !== 1'b1 || mif.imem_addr_out !== 32'h10) begin nmis++; $display("FAIL redir_drop0: got req=%b addr=%h exp req=1 addr=10", mif.imem_req_out, mif.imem_addr_out); end
        step();
        nvec++; if (mif.imem_addr_out !== 32'h10 || valid_out !== 1'b0) begin nmis++; $display("FAIL redir_drop1: got addr=%h v=%b exp addr=10 v=0", mif.imem_addr_out, valid_out); end
        step();
        nvec++; if (mif.imem_addr_out !== 32'h100 || mif.imem_req_out !== 1'b1) begin nmis++; $display("FAIL redir_newaddr: got req=%b addr=%h exp req=1 addr=100", mif.imem_req_out, mif.imem_addr_out); end
        nvec++; if (valid_out !== 1'b0) begin nmis++; $display("FAIL redir_discard: got %b exp 0", valid_out); end
        step(); step();
        nvec++; if (valid_out !== 1'b0) begin nmis++; $display("FAIL redir_wait: got %b exp 0", valid_out); end
        step();
        nvec++; if (valid_out !== 1'b1 || pc_out !== 32'h100) begin nmis++; $display("FAIL redir_first: got v=%b pc=%h exp v=1 pc=100", valid_out, pc_out); end
        nvec++; if (instr_out !== 32'hA5A5_0100) begin nmis++; $display("FAIL redir_first_instr: got %h exp a5a50100", instr_out); end
    endtask

    task automatic test_redirect_ack_pop();
        lat = 1;
        apply_reset();
        repeat (3) step();
        nvec++; if (pc_out !== 32'h4 || mif.imem_addr_out !== 32'h8) begin nmis++; $display("FAIL rap_setup: got pc=%h addr=%h exp pc=4 addr=8", pc_out, mif.imem_addr_out); end
        redirect_in = 1'b1; redirect_pc_in = 32'h0000_0202;
        step();
        redirect_in = 1'b0; redirect_pc_in = '0;
        nvec++; if (valid_out !== 1'b0 || instr_out !== 32'h13) begin nmis++; $display("FAIL rap_flush: got v=%b i=%h exp v=0 i=00000013", valid_out, instr_out); end
        nvec++; if (mif.imem_req_out !== 1'b1 || mif.imem_addr_out !== 32'h200) begin nmis++; $display("FAIL rap_addr: got req=%b addr=%h exp req=1 addr=200", mif.imem_req_out, mif.imem_addr_out); end
        for (int k = 0; k < 2; k++) begin
            step();
            nvec++; if (valid_out !== 1'b1 || pc_out !== 32'(512 + 4*k)) begin nmis++; $display("FAIL rap_pc[%0d]: got v=%b pc=%h exp v=1 pc=%h", k, valid_out, pc_out, 32'(512 + 4*k)); end
            nvec++; if (instr_out !== (32'(512 + 4*k) ^ 32'hA5A5_0000)) begin nmis++; $display("FAIL rap_instr[%0d]: got %h exp %h", k, instr_out, 32'(512 + 4*k) ^ 32'hA5A5_0000); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_reset_midwait();
        test_redirect_inflight();
        test_redirect_ack_pop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
        $fatal(1);
    end
endmodule
